// File: rtl/md_quote_frame_parser_pkg.sv
// md_pkg: shared types and XGMII control constants for the quote frame parser
package md_pkg;
   localparam int FIELD_W = 32;
   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM = 8'hFD;
   localparam logic [7:0] XGMII_CTRL_LANE0 = 8'h01;
   typedef enum logic [2:0] {S_IDLE, S_HDR, S_SYM, S_PRC, S_QTY, S_CSUM, S_EOF} parse_state_e;
   typedef struct packed {
      logic [7:0] mtype;
      logic [FIELD_W-1:0] symbol;
      logic [FIELD_W-1:0] price;
      logic [FIELD_W-1:0] qty;
   } quote_t;
endpackage

// File: rtl/md_sync_fifo.sv
// md_sync_fifo: first-word-fall-through FIFO with registered head, push+pop allowed when full
module md_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push_i,
   input  logic pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic valid_o,
   output logic full_o,
   output logic [WIDTH-1:0] dout_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] head_q;
   logic [AW-1:0] rd_q, wr_q, rd_nx;
   logic [AW:0] cnt_q;
   logic pop, push;
   assign valid_o = cnt_q != '0;
   assign full_o = cnt_q == (AW+1)'(DEPTH);
   assign pop = pop_i && valid_o;
   assign push = push_i && (!full_o || pop);
   assign rd_nx = rd_q + AW'(1);
   assign dout_o = head_q;
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= din_i;
   // head_q always mirrors the oldest entry; it holds its last value once empty
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
         head_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + AW'(1);
         if (pop) rd_q <= rd_nx;
         cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
         if (pop && cnt_q > (AW+1)'(1)) head_q <= mem_q[rd_nx];
         else if (push && (cnt_q == '0 || pop)) head_q <= din_i;
      end
   end
endmodule

// File: rtl/md_quote_frame_parser.sv
// md_quote_frame_parser: parses XGMII quote frames, validates them and queues good quotes
module md_quote_frame_parser
   import md_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int FIELD_W = md_pkg::FIELD_W,
   parameter logic [15:0] EXP_LEN = 16'h0020,
   parameter logic [7:0] TYPE_MASK = 8'h02,
   parameter int FIFO_DEPTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic [DATA_WIDTH-1:0] xgmii_rxd,
   input  logic [DATA_WIDTH/8-1:0] xgmii_rxc,
   output logic quote_valid,
   input  logic quote_ready,
   output logic [7:0] quote_type,
   output logic [FIELD_W-1:0] quote_symbol,
   output logic [FIELD_W-1:0] quote_price,
   output logic [FIELD_W-1:0] quote_qty,
   output logic [31:0] cnt_ok,
   output logic [31:0] cnt_err,
   output logic [31:0] cnt_drop
);
   localparam int CW = DATA_WIDTH/8;
   localparam int QW = 8 + 3*FIELD_W;
   parse_state_e state_q, state_d;
   logic [7:0] type_q;
   logic [15:0] len_q;
   logic [FIELD_W-1:0] sym_q, prc_q, qty_q, csum_q;
   logic [31:0] ok_q, err_q, drop_q;
   logic is_start, is_term, is_data, err, push, good, pop, full, ok_inc, drop_inc;
   logic unused_rxd;
   assign unused_rxd = ^xgmii_rxd[DATA_WIDTH-1:FIELD_W];
   assign is_start = xgmii_rxc == CW'(XGMII_CTRL_LANE0) && xgmii_rxd[7:0] == XGMII_START;
   assign is_term = xgmii_rxc == CW'(XGMII_CTRL_LANE0) && xgmii_rxd[7:0] == XGMII_TERM;
   assign is_data = xgmii_rxc == '0;
   assign good = type_q < 8'd8 && TYPE_MASK[type_q[2:0]] && len_q == EXP_LEN
                 && csum_q == (sym_q ^ prc_q ^ qty_q);
   assign pop = quote_valid && quote_ready;
   assign ok_inc = push && (!full || pop);
   assign drop_inc = push && full && !pop;
   assign cnt_ok = ok_q;
   assign cnt_err = err_q;
   assign cnt_drop = drop_q;
   // a START anywhere inside a frame aborts it and opens the next one
   always_comb begin
      state_d = state_q;
      err = 1'b0;
      push = 1'b0;
      case (state_q)
         S_IDLE: state_d = is_start ? S_HDR : S_IDLE;
         S_EOF: begin
            state_d = is_start ? S_HDR : S_IDLE;
            push = is_term && good;
            err = !push;
         end
         default: begin
            state_d = is_start ? S_HDR : is_data ? parse_state_e'(state_q + 3'd1) : S_IDLE;
            err = !is_data;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ok_q <= '0;
         err_q <= '0;
         drop_q <= '0;
      end else begin
         state_q <= state_d;
         if (is_data) begin
            if (state_q == S_HDR) begin
               type_q <= xgmii_rxd[23:16];
               len_q <= xgmii_rxd[15:0];
            end
            if (state_q == S_SYM) sym_q <= xgmii_rxd[FIELD_W-1:0];
            if (state_q == S_PRC) prc_q <= xgmii_rxd[FIELD_W-1:0];
            if (state_q == S_QTY) qty_q <= xgmii_rxd[FIELD_W-1:0];
            if (state_q == S_CSUM) csum_q <= xgmii_rxd[FIELD_W-1:0];
         end
         if (ok_inc && ~&ok_q) ok_q <= ok_q + 32'd1;
         if (err && ~&err_q) err_q <= err_q + 32'd1;
         if (drop_inc && ~&drop_q) drop_q <= drop_q + 32'd1;
      end
   end
   md_sync_fifo #(.WIDTH(QW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push_i(ok_inc),
      .pop_i(quote_ready),
      .din_i({type_q, sym_q, prc_q, qty_q}),
      .valid_o(quote_valid),
      .full_o(full),
      .dout_o({quote_type, quote_symbol, quote_price, quote_qty})
   );
endmodule

// File: tb/tb_md_quote_frame_parser.sv
// tb_md_quote_frame_parser: randomized scoreboard bench with a frame-level reference model
module tb_md_quote_frame_parser;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [63:0] xgmii_rxd;
   logic [7:0] xgmii_rxc;
   logic quote_valid, quote_ready;
   logic [7:0] quote_type;
   logic [31:0] quote_symbol, quote_price, quote_qty, cnt_ok, cnt_err, cnt_drop;
   localparam logic [63:0] IDLE_D = {8{8'h07}};
   localparam logic [31:0] AAPL = 32'h4141504C;
   localparam logic [31:0] MSFT = 32'h4D534654;
   int checks = 0, failures = 0;
   int exp_ok = 0, exp_err = 0, exp_drop = 0;
   bit rand_ready = 0;
   logic [103:0] sb[$];
   always #5 clk = ~clk;
   md_quote_frame_parser dut (
      .clk(clk), .rst_n(rst_n), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
      .quote_valid(quote_valid), .quote_ready(quote_ready), .quote_type(quote_type),
      .quote_symbol(quote_symbol), .quote_price(quote_price), .quote_qty(quote_qty),
      .cnt_ok(cnt_ok), .cnt_err(cnt_err), .cnt_drop(cnt_drop)
   );
   task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   // monitor: pops the scoreboard on every accepted quote, and checks stability under backpressure
   logic [103:0] prev_q;
   bit prev_hold = 0;
   always @(negedge clk) begin
      if (!rst_n) prev_hold = 0;
      else begin
         if (prev_hold) chk("hold_stable", {quote_type, quote_symbol, quote_price, quote_qty}, prev_q);
         if (quote_valid && quote_ready) begin
            if (sb.size() == 0) chk("unexpected_quote", 104'(quote_valid), 104'(0));
            else chk("quote", {quote_type, quote_symbol, quote_price, quote_qty}, sb.pop_front());
         end
         prev_hold = quote_valid && !quote_ready;
         prev_q = {quote_type, quote_symbol, quote_price, quote_qty};
      end
   end
   function automatic bit is_good(input logic [7:0] t, input logic [15:0] l,
                                  input logic [31:0] s, input logic [31:0] p,
                                  input logic [31:0] q, input logic [31:0] c);
      return t < 8 && ((8'h02 >> t) & 8'h01) != 0 && l == 16'h0020 && c == (s ^ p ^ q);
   endfunction
   task automatic beat(input logic [7:0] c, input logic [63:0] d);
      xgmii_rxc = c;
      xgmii_rxd = d;
      if (rand_ready) quote_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      beat(8'hFF, IDLE_D);
   endtask
   task automatic start_b();
      beat(8'h01, {$urandom, 24'($urandom), 8'hFB});
   endtask
   task automatic hdr_b(input logic [7:0] t, input logic [15:0] l);
      beat(8'h00, {$urandom, 8'($urandom), t, l});
   endtask
   task automatic data_b(input logic [31:0] f);
      beat(8'h00, {$urandom, f});
   endtask
   // the model decides at the TERM beat, after the monitor has taken this cycle's pop
   task automatic term_b(input bit g, input logic [103:0] q);
      xgmii_rxc = 8'h01;
      xgmii_rxd = {$urandom, 24'($urandom), 8'hFD};
      if (rand_ready) quote_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      if (!g) exp_err++;
      else if (sb.size() == 8) exp_drop++;
      else begin
         sb.push_back(q);
         exp_ok++;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic frame(input logic [7:0] t, input logic [15:0] l, input logic [31:0] s,
                        input logic [31:0] p, input logic [31:0] q, input logic [31:0] c);
      start_b();
      hdr_b(t, l);
      data_b(s);
      data_b(p);
      data_b(q);
      data_b(c);
      term_b(is_good(t, l, s, p, q, c), {t, s, p, q});
   endtask
   task automatic good_frame(input logic [31:0] s, input logic [31:0] p, input logic [31:0] q);
      frame(8'd1, 16'h0020, s, p, q, s ^ p ^ q);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
      sb.delete();
      exp_ok = 0;
      exp_err = 0;
      exp_drop = 0;
   endtask
   task automatic chk_cnt(input string tag);
      chk({tag, "_ok"}, 104'(cnt_ok), 104'(exp_ok));
      chk({tag, "_err"}, 104'(cnt_err), 104'(exp_err));
      chk({tag, "_drop"}, 104'(cnt_drop), 104'(exp_drop));
   endtask
   task automatic drain(input string tag);
      rand_ready = 0;
      quote_ready = 1'b1;
      for (int i = 0; i < 100 && sb.size() != 0; i++) idle();
      idle();
      idle();
      chk({tag, "_drained"}, 104'(sb.size()), 104'(0));
      chk({tag, "_valid_low"}, 104'(quote_valid), 104'(0));
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      quote_ready = 1'b0;
      xgmii_rxc = 8'hFF;
      xgmii_rxd = IDLE_D;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 104'(quote_valid), 104'(0));
      chk("rst_quote", {quote_type, quote_symbol, quote_price, quote_qty}, 104'(0));
      chk("rst_cnt", {cnt_ok, cnt_err, cnt_drop}, 104'(0));
      rst_n = 1'b1;
      idle();
      // AAPL good frame and latency
      quote_ready = 1'b1;
      good_frame(AAPL, 32'h000186A0, 32'h000000C8);
      chk("t1_latency", 104'(quote_valid), 104'(1));
      idle();
      idle();
      chk("t1_ok", 104'(cnt_ok), 104'(1));
      // bad checksum
      frame(8'd1, 16'h0020, AAPL, 32'h000186A0, 32'h000000C8, 32'h000000FF);
      idle();
      chk("t2_err", 104'(cnt_err), 104'(1));
      chk("t2_ok", 104'(cnt_ok), 104'(1));
      chk("t2_valid", 104'(quote_valid), 104'(0));
      // backpressure: 10 frames into 8 entries
      do_reset();
      quote_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         good_frame(MSFT, 32'd1000 + 32'(i), 32'd10 + 32'(i));
         idle();
      end
      chk("t3_drop", 104'(cnt_drop), 104'(2));
      chk("t3_ok", 104'(cnt_ok), 104'(8));
      drain("t3");
      // START during the QTY beat aborts the first frame
      do_reset();
      start_b();
      hdr_b(8'd1, 16'h0020);
      data_b(AAPL);
      data_b(32'd5);
      exp_err++;
      good_frame(MSFT, 32'd77, 32'd3);
      idle();
      chk("t4_err", 104'(cnt_err), 104'(1));
      chk("t4_ok", 104'(cnt_ok), 104'(1));
      drain("t4");
      // wrong type, wrong length, missing TERM
      do_reset();
      frame(8'd2, 16'h0020, AAPL, 32'd1, 32'd2, AAPL ^ 32'd3);
      frame(8'd1, 16'h0018, AAPL, 32'd1, 32'd2, AAPL ^ 32'd3);
      idle();
      chk("t5_err2", 104'(cnt_err), 104'(2));
      start_b();
      hdr_b(8'd1, 16'h0020);
      data_b(AAPL);
      data_b(32'd1);
      data_b(32'd2);
      data_b(AAPL ^ 32'd3);
      data_b(32'd9);
      exp_err++;
      idle();
      chk("t5_err3", 104'(cnt_err), 104'(3));
      chk("t5_ok", 104'(cnt_ok), 104'(0));
      // reset mid-frame with quotes queued
      do_reset();
      quote_ready = 1'b0;
      for (int i = 0; i < 3; i++) good_frame(AAPL, 32'(i), 32'd1);
      chk("t6_valid", 104'(quote_valid), 104'(1));
      start_b();
      hdr_b(8'd1, 16'h0020);
      do_reset();
      chk("t6_rst_valid", 104'(quote_valid), 104'(0));
      chk("t6_rst_cnt", {cnt_ok, cnt_err, cnt_drop}, 104'(0));
      chk("t6_rst_quote", {quote_type, quote_symbol, quote_price, quote_qty}, 104'(0));
      quote_ready = 1'b1;
      good_frame(MSFT, 32'd42, 32'd7);
      idle();
      chk("t6_ok", 104'(cnt_ok), 104'(1));
      drain("t6");
      // random traffic with 1-beat gaps and random backpressure
      do_reset();
      rand_ready = 1;
      for (int n = 0; n < 300; n++) begin
         logic [31:0] s, p, q;
         int kind;
         s = $urandom;
         p = $urandom;
         q = $urandom;
         kind = $urandom_range(0, 9);
         case (kind)
            0: frame(8'd1, 16'h0020, s, p, q, s ^ p ^ q ^ (32'd1 << $urandom_range(0, 31)));
            1: frame(8'($urandom_range(2, 255)), 16'h0020, s, p, q, s ^ p ^ q);
            2: frame(8'd1, 16'($urandom_range(0, 31)), s, p, q, s ^ p ^ q);
            3: begin
               start_b();
               for (int k = $urandom_range(0, 4); k > 0; k--) data_b($urandom);
               exp_err++;
               good_frame(s, p, q);
            end
            4: begin
               start_b();
               hdr_b(8'd1, 16'h0020);
               data_b(s);
               data_b(p);
               data_b(q);
               data_b(s ^ p ^ q);
               data_b($urandom);
               exp_err++;
            end
            default: good_frame(s, p, q);
         endcase
         if ($urandom_range(0, 3) == 0) data_b($urandom);
         else idle();
      end
      drain("t7");
      chk_cnt("t7");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
